// File: rtl/hyperbus_wb_bridge.sv
// hyperbus_wb_bridge
// Wishbone B4 classic slave in front of the Hyperbus FIFO stage. Each single
// 32-bit bus cycle becomes one rrq or wrq pulse. Writes are posted and paced
// by tx_ready plus a guard window; reads block until rx_valid returns data.
// Optional build macro: HYPERBUS_WB_TIMEOUT_EN (read-return timeout -> err).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for cyc&stb; legality checked and address/data latched
// S_WRITE | holding write until tx_ready=1 and guard window has expired
// S_READ  | rrq issued, waiting for rx_valid (or timeout when enabled)
// S_RESP  | ack or err visible for one cycle, then back to idle

module hyperbus_wb_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int GUARD      = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   input  logic [3:0]            wb_sel_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   output logic                  rrq,
   output logic                  wrq,
   output logic [ADDR_WIDTH-1:0] adr_o,
   output logic [DATA_WIDTH-1:0] tx_dat_o,
   input  logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] rx_dat_i,
   input  logic                  rx_valid
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [3:0]            r_guard_cnt;
   logic                  r_ack;
   logic                  r_err;
   logic                  r_rrq;
   logic [ADDR_WIDTH-1:0] r_adr;
   logic [DATA_WIDTH-1:0] r_tx_dat;
   logic [DATA_WIDTH-1:0] r_rd_dat;

   logic w_req;
   logic w_illegal;
   logic w_wr_go;
   logic w_rd_done;
   logic w_to_expire;
   logic w_ack_nxt;
   logic w_err_nxt;
   logic w_rrq_nxt;
   logic w_latch_adr;
   logic w_latch_dat;

   assign w_req     = wb_cyc_i & wb_stb_i;
   assign w_illegal = (wb_sel_i != 4'hF) | (wb_adr_i[1:0] != 2'b00);
   // wrq is combinational so the FIFO stage sees it in the first WRITE cycle,
   // one cycle ahead of the registered ack.
   assign w_wr_go   = (r_state == S_WRITE) & tx_ready & (r_guard_cnt == 4'd0);
   assign w_rd_done = (r_state == S_READ) & rx_valid;

`ifdef HYPERBUS_WB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);

   logic [TO_W-1:0] r_to_cnt;

   // Timeout counter: cleared when a read is launched, counts READ cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to_cnt <= '0;
      end else if (w_rrq_nxt) begin
         r_to_cnt <= '0;
      end else if (r_state == S_READ) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   // Data arriving on the expiry cycle takes priority over the timeout.
   assign w_to_expire = (r_state == S_READ) & ~rx_valid &
                        (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
   // READ waits forever; TIMEOUT only sizes the counter in the timeout build.
   assign w_to_expire = 1'b0 & (TIMEOUT != 0);
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_illegal) begin
                  w_state_nxt = S_RESP;
               end else if (wb_we_i) begin
                  w_state_nxt = S_WRITE;
               end else begin
                  w_state_nxt = S_READ;
               end
            end
         end
         S_WRITE: begin
            if (w_wr_go) begin
               w_state_nxt = S_RESP;
            end
         end
         S_READ: begin
            if (w_rd_done | w_to_expire) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode: next values for the registered bus/FIFO outputs.
   always_comb begin
      w_ack_nxt   = 1'b0;
      w_err_nxt   = 1'b0;
      w_rrq_nxt   = 1'b0;
      w_latch_adr = 1'b0;
      w_latch_dat = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_err_nxt   = w_illegal;
               w_latch_adr = ~w_illegal;
               w_latch_dat = ~w_illegal & wb_we_i;
               w_rrq_nxt   = ~w_illegal & ~wb_we_i;
            end
         end
         S_WRITE: begin
            w_ack_nxt = w_wr_go;
         end
         S_READ: begin
            w_ack_nxt = w_rd_done;
            w_err_nxt = w_to_expire;
         end
         default: begin
            w_ack_nxt = 1'b0;
         end
      endcase
   end

   // Registered outputs and latched request fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
         r_rrq    <= 1'b0;
         r_adr    <= '0;
         r_tx_dat <= '0;
         r_rd_dat <= '0;
      end else begin
         r_ack <= w_ack_nxt;
         r_err <= w_err_nxt;
         r_rrq <= w_rrq_nxt;
         if (w_latch_adr) begin
            r_adr <= {1'b0, wb_adr_i[ADDR_WIDTH-1:1]};
         end
         if (w_latch_dat) begin
            r_tx_dat <= wb_dat_i;
         end
         if (w_rd_done) begin
            r_rd_dat <= rx_dat_i;
         end
      end
   end

   // Guard window: tx_ready lags the FIFO flags right after a write pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_guard_cnt <= 4'd0;
      end else if (w_wr_go) begin
         r_guard_cnt <= 4'(GUARD);
      end else if (r_guard_cnt != 4'd0) begin
         r_guard_cnt <= r_guard_cnt - 4'd1;
      end
   end

   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;
   assign wb_dat_o = r_rd_dat;
   assign rrq      = r_rrq;
   assign wrq      = w_wr_go;
   assign adr_o    = r_adr;
   assign tx_dat_o = r_tx_dat;

endmodule

// File: doc/hyperbus_wb_bridge.md
# hyperbus_wb_bridge

Wishbone B4 classic slave that converts single 32-bit bus cycles into the one-cycle `rrq`/`wrq` request pulses of the Hyperbus FIFO stage. It sits directly upstream of that stage in the user clock domain. It drives the address and TX data, consumes the `rx_valid`/`rx_dat_o` read return, and throttles writes on `tx_ready`. Exactly one transaction is in flight at a time. Writes are posted; reads block until data returns.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: Wishbone byte address width, equal to the FIFO stage's address width.
- `DATA_WIDTH`, default 32: Wishbone data width, equal to the FIFO stage's data width. Only 32 is supported.
- `GUARD`, default 4: cycles after a write pulse during which `tx_ready` is ignored, because it lags the FIFO flags. Legal range 1–15.
- `TIMEOUT`, default 1023: read-return timeout in cycles. Used only when `HYPERBUS_WB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: user clock.
- `rst` in 1: asynchronous, active-high reset.
- `wb_adr_i` in ADDR_WIDTH: byte address.
- `wb_dat_i` in DATA_WIDTH: write data.
- `wb_sel_i` in 4: byte selects.
- `wb_we_i` in 1: write enable.
- `wb_cyc_i` in 1: cycle.
- `wb_stb_i` in 1: strobe.
- `wb_dat_o` out DATA_WIDTH: read data.
- `wb_ack_o` out 1: acknowledge.
- `wb_err_o` out 1: error.
- `rrq` out 1: read request pulse to the FIFO stage.
- `wrq` out 1: write request pulse to the FIFO stage.
- `adr_o` out ADDR_WIDTH: Hyperbus halfword address to the FIFO stage.
- `tx_dat_o` out DATA_WIDTH: write data to the FIFO stage.
- `tx_ready` in 1: TX FIFO empty, from the FIFO stage.
- `rx_dat_i` in DATA_WIDTH: read data from the FIFO stage.
- `rx_valid` in 1: read-data pulse from the FIFO stage. It is never back-pressured.

## Operation
- State machine states: IDLE, WRITE, READ, RESP.
- A request is `wb_cyc_i & wb_stb_i`, sampled only in IDLE.
- Address mapping: `adr_o = {1'b0, wb_adr_i[ADDR_WIDTH-1:1]}`, i.e. byte address to halfword address.
- IDLE, illegal request (`wb_sel_i != 4'hF` or `wb_adr_i[1:0] != 0`):
  - Set `wb_err_o` = 1 and go to RESP.
  - No `rrq`/`wrq` is issued.
- IDLE, legal write:
  - Latch `adr_o` and `tx_dat_o`, go to WRITE.
- WRITE:
  - Wait until `tx_ready` = 1 and `guard_cnt` = 0.
  - Then pulse `wrq` for 1 cycle, set `wb_ack_o` = 1, load `guard_cnt` = GUARD, go to RESP.
- IDLE, legal read:
  - Latch `adr_o`, pulse `rrq` for 1 cycle, go to READ.
- READ, on `rx_valid`:
  - `wb_dat_o <= rx_dat_i`, set `wb_ack_o` = 1, go to RESP.
- RESP:
  - Drop `wb_ack_o`/`wb_err_o`, return to IDLE.
  - The master must deassert `wb_stb_i` or present a new request in this cycle.
- `guard_cnt` decrements every cycle while nonzero, in every state.
- An `rx_valid` arriving in IDLE, WRITE or RESP is dropped.
- `rrq` and `wrq` are never high together, and never high for 2 consecutive cycles.
- `adr_o`/`tx_dat_o` hold their values until the next legal request is latched.

## Timing
- Reset values: all outputs 0, state IDLE, `guard_cnt` 0, timeout counter 0.
- Reset is asynchronous. Asserting `rst` mid-transaction aborts it with no ack and no err. A later `rx_valid` for the aborted read is dropped.
- Write, with `tx_ready` high and guard expired:
  - Cycle 0: request seen in IDLE.
  - Cycle 1: `wrq` pulse.
  - Cycle 2: `wb_ack_o` = 1.
  - Write latency to ack is 2 cycles.
- Read:
  - `rrq` pulses on the cycle after the request.
  - `wb_ack_o` rises on the cycle after the `rx_valid` pulse, with `wb_dat_o` valid in the same cycle.
- Error: `wb_err_o` is high for 1 cycle, the cycle after the request.
- Back-to-back writes: the second `wrq` comes no earlier than GUARD cycles after the first, and only once `tx_ready` = 1.
- Simultaneous `rx_valid` and a request in IDLE: the request is processed and the `rx_valid` is dropped.

## Configuration
- Macro: `HYPERBUS_WB_TIMEOUT_EN`.
- Defined:
  - A counter runs in READ and counts TIMEOUT cycles without `rx_valid`.
  - On expiry, set `wb_err_o` = 1, go to RESP; `wb_dat_o` is unchanged.
  - The counter clears on entry to READ.
  - If `rx_valid` arrives on the same cycle the timeout expires, data wins: the response is an ack.
- Undefined:
  - READ waits indefinitely.
  - No timeout counter is synthesised.

## Test plan
- Write to 0x0000_0010 with data 0xDEADBEEF, sel F, `tx_ready` = 1 -> one-cycle `wrq`, `adr_o` = 0x0000_0008, `tx_dat_o` = 0xDEADBEEF, ack 2 cycles after the request.
- Read from 0x0000_0010; `rx_valid` with 0xCAFEF00D asserted 7 cycles after `rrq` -> `adr_o` = 0x8, `wb_dat_o` = 0xCAFEF00D, ack on the next cycle, exactly one `rrq`.
- Two back-to-back writes with GUARD = 4 and `tx_ready` held high -> `wrq` pulses at least 4 cycles apart. With `tx_ready` held low -> the second write stalls with no `wrq` and no ack.
- sel = 4'h3 or address 0x0000_0002 -> `wb_err_o` pulse, no `rrq`/`wrq`, then the next legal request completes normally.
- With `HYPERBUS_WB_TIMEOUT_EN` and TIMEOUT = 16, a read with no `rx_valid` -> err 16–17 cycles after `rrq`. A late `rx_valid` is then ignored and the following read returns its own data.
- Assert `rst` while in READ -> all outputs 0 immediately, no ack. A subsequent `rx_valid` is dropped, and a new read works.
